// File: rtl/axi_dp_instr_ram.sv
// Dual-port instruction RAM: AXI4-Lite slave for loading plus a fixed-latency fetch port.
// Optional macro INSTR_MEM_WPROTECT_EN drops AXI writes committed while cpu_run is high.
module axi_dp_instr_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 256,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                    S_AXI_ACLK,
  input  logic                    S_AXI_ARESETN,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY,
  input  logic                    fetch_en,
  input  logic [IDX_W-1:0]        fetch_idx,
  output logic [DATA_WIDTH-1:0]   fetch_data,
  output logic                    fetch_valid,
  input  logic                    cpu_run
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int AIDX_W = ADDR_WIDTH - LSB;

  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  wstate_t               w_state, w_next;
  rstate_t               r_state, r_next;
  logic                  ready_en;
  logic                  aw_latched, w_latched;
  logic [AIDX_W-1:0]     aw_idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic [1:0]            bresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic                  aw_hs, w_hs, ar_hs, commit_ok;
  logic [31:0]           aw_idx_ext, ar_idx_ext;
  logic                  unused_ok;

  assign aw_idx_ext = 32'(aw_idx_q);
  assign ar_idx_ext = 32'(S_AXI_ARADDR[ADDR_WIDTH-1:LSB]);
  assign unused_ok  = &{1'b0, cpu_run, S_AXI_AWADDR[LSB-1:0], S_AXI_ARADDR[LSB-1:0]};

`ifdef INSTR_MEM_WPROTECT_EN
  assign commit_ok = (aw_idx_ext < 32'(DEPTH)) && !cpu_run;
`else
  assign commit_ok = aw_idx_ext < 32'(DEPTH);
`endif

  // Holds all READY lines low until the first edge after reset release.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) ready_en <= 1'b0;
    else                ready_en <= 1'b1;
  end

  always_comb begin
    w_next        = w_state;
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    case (w_state)
      W_IDLE: begin
        S_AXI_AWREADY = ready_en && !aw_latched;
        S_AXI_WREADY  = ready_en && !w_latched;
        if ((aw_latched || (S_AXI_AWVALID && S_AXI_AWREADY)) &&
            (w_latched  || (S_AXI_WVALID  && S_AXI_WREADY)))
          w_next = W_COMMIT;
      end
      W_COMMIT: w_next = W_RESP;
      W_RESP: begin
        S_AXI_BVALID = 1'b1;
        if (S_AXI_BREADY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  assign aw_hs       = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs        = S_AXI_WVALID && S_AXI_WREADY;
  assign S_AXI_BRESP = bresp_q;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_state    <= W_IDLE;
      aw_latched <= 1'b0;
      w_latched  <= 1'b0;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= '0;
    end else begin
      w_state <= w_next;
      if (aw_hs) begin
        aw_latched <= 1'b1;
        aw_idx_q   <= S_AXI_AWADDR[ADDR_WIDTH-1:LSB];
      end
      if (w_hs) begin
        w_latched <= 1'b1;
        wdata_q   <= S_AXI_WDATA;
        wstrb_q   <= S_AXI_WSTRB;
      end
      if (w_state == W_COMMIT) bresp_q <= commit_ok ? 2'b00 : 2'b10;
      if (w_state == W_RESP && S_AXI_BREADY) begin
        aw_latched <= 1'b0;
        w_latched  <= 1'b0;
      end
    end
  end

  // Storage is deliberately unreset; readers on the same edge see the old word.
  always_ff @(posedge S_AXI_ACLK) begin
    if (w_state == W_COMMIT && commit_ok) begin
      for (int unsigned b = 0; b < STRB_W; b++)
        if (wstrb_q[b]) mem[aw_idx_ext[IDX_W-1:0]][b*8 +: 8] <= wdata_q[b*8 +: 8];
    end
  end

  always_comb begin
    r_next        = r_state;
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    case (r_state)
      R_IDLE: begin
        S_AXI_ARREADY = ready_en;
        if (S_AXI_ARVALID && ready_en) r_next = R_DATA;
      end
      R_DATA: begin
        S_AXI_RVALID = 1'b1;
        if (S_AXI_RREADY) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  assign ar_hs       = S_AXI_ARVALID && S_AXI_ARREADY;
  assign S_AXI_RDATA = rdata_q;
  assign S_AXI_RRESP = rresp_q;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state <= R_IDLE;
      rdata_q <= '0;
      rresp_q <= '0;
    end else begin
      r_state <= r_next;
      if (ar_hs) begin
        if (ar_idx_ext < 32'(DEPTH)) begin
          rdata_q <= mem[ar_idx_ext[IDX_W-1:0]];
          rresp_q <= 2'b00;
        end else begin
          rdata_q <= '0;
          rresp_q <= 2'b10;
        end
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      fetch_valid <= 1'b0;
      fetch_data  <= '0;
    end else begin
      fetch_valid <= fetch_en;
      if (fetch_en) fetch_data <= mem[fetch_idx];
    end
  end
endmodule

// File: tb/tb_axi_dp_instr_ram.sv
// Directed self-checking bench for axi_dp_instr_ram (default 32-bit, 256-word build).
module tb_axi_dp_instr_ram;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic [11:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b1;
  logic        fetch_en = 1'b0;
  logic [7:0]  fetch_idx = '0;
  logic [31:0] fetch_data;
  logic        fetch_valid;
  logic        cpu_run = 1'b0;

  int checks = 0;
  int errors = 0;

  axi_dp_instr_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .DEPTH(256)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .fetch_en(fetch_en), .fetch_idx(fetch_idx), .fetch_data(fetch_data),
    .fetch_valid(fetch_valid), .cpu_run(cpu_run)
  );

  always #5 clk = ~clk;

  // Called and resumed 1 time unit after a rising edge; resp stays 2'b11 if no response arrives.
  task automatic do_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_lag, input int w_lag, output logic [1:0] resp, output int bcnt);
    bit aw_fire, w_fire, b_seen;
    int post;
    b_seen = 0; bcnt = 0; resp = 2'b11; post = 0;
    bready = 1'b1;
    for (int c = 0; c < 40 && post < 3; c++) begin
      if (c == aw_lag) begin awvalid = 1'b1; awaddr = addr; end
      if (c == w_lag) begin wvalid = 1'b1; wdata = data; wstrb = strb; end
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      if (bvalid) begin
        bcnt++;
        if (!b_seen) resp = bresp;
        b_seen = 1;
      end
      if (b_seen) post++;
      @(posedge clk); #1;
      if (aw_fire) awvalid = 1'b0;
      if (w_fire) wvalid = 1'b0;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
  endtask

  task automatic do_read(input logic [11:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit ar_fire, done;
    done = 0; data = '0; resp = 2'b11;
    rready = 1'b1; arvalid = 1'b1; araddr = addr;
    for (int c = 0; c < 40 && !done; c++) begin
      ar_fire = arvalid && arready;
      if (rvalid) begin data = rdata; resp = rresp; done = 1; end
      @(posedge clk); #1;
      if (ar_fire) arvalid = 1'b0;
    end
    arvalid = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({awready, wready, arready, bvalid, rvalid, fetch_valid} !== 6'b0) begin errors++; $display("FAIL reset_flags: got %b expected 000000", {awready, wready, arready, bvalid, rvalid, fetch_valid}); end
    checks++; if ({bresp, rresp, rdata, fetch_data} !== 68'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", {bresp, rresp, rdata, fetch_data}); end
    rst_n = 1'b1;
    #1;
    checks++; if ({awready, wready, arready} !== 3'b000) begin errors++; $display("FAIL ready_before_edge: got %b expected 000", {awready, wready, arready}); end
    @(posedge clk); #1;
    checks++; if ({awready, wready, arready} !== 3'b111) begin errors++; $display("FAIL ready_after_edge: got %b expected 111", {awready, wready, arready}); end
  endtask

  task automatic test_basic_write_read();
    logic [1:0] r; int n; logic [31:0] d;
    do_write(12'h008, 32'hDEADBEEF, 4'hF, 0, 2, r, n);
    checks++; if (r !== 2'b00) begin errors++; $display("FAIL basic_bresp: got %b expected 00", r); end
    checks++; if (n !== 1) begin errors++; $display("FAIL basic_bpulse: got %0d expected 1", n); end
    do_read(12'h008, d, r);
    checks++; if (d !== 32'hDEADBEEF || r !== 2'b00) begin errors++; $display("FAIL basic_read: got %h/%b expected deadbeef/00", d, r); end
  endtask

  task automatic test_strobe();
    logic [1:0] r; int n; logic [31:0] d;
    do_write(12'h004, 32'hFFFFFFFF, 4'hF, 0, 0, r, n);
    do_write(12'h004, 32'h11223344, 4'h5, 0, 0, r, n);
    checks++; if (r !== 2'b00 || n !== 1) begin errors++; $display("FAIL strobe_bresp: got %b/%0d expected 00/1", r, n); end
    do_read(12'h004, d, r);
    checks++; if (d !== 32'hFF22FF44) begin errors++; $display("FAIL strobe_read: got %h expected ff22ff44", d); end
    do_write(12'h004, 32'h00000000, 4'h0, 0, 0, r, n);
    do_read(12'h004, d, r);
    checks++; if (d !== 32'hFF22FF44) begin errors++; $display("FAIL strobe_zero: got %h expected ff22ff44", d); end
    // W ahead of AW, with non-zero low address bits that must be ignored
    do_write(12'h00E, 32'h0C0C0C0C, 4'hF, 3, 0, r, n);
    checks++; if (r !== 2'b00 || n !== 1) begin errors++; $display("FAIL w_first_bresp: got %b/%0d expected 00/1", r, n); end
    do_read(12'h00C, d, r);
    checks++; if (d !== 32'h0C0C0C0C) begin errors++; $display("FAIL w_first_read: got %h expected 0c0c0c0c", d); end
  endtask

  task automatic test_out_of_range();
    logic [1:0] r; int n; logic [31:0] d;
    do_write(12'h000, 32'h01020304, 4'hF, 0, 0, r, n);
    do_write(12'h3FC, 32'hCAFEF00D, 4'hF, 0, 0, r, n);
    checks++; if (r !== 2'b00) begin errors++; $display("FAIL last_word_bresp: got %b expected 00", r); end
    do_write(12'h400, 32'hA5A5A5A5, 4'hF, 0, 1, r, n);
    checks++; if (r !== 2'b10 || n !== 1) begin errors++; $display("FAIL oor_bresp: got %b/%0d expected 10/1", r, n); end
    do_read(12'h400, d, r);
    checks++; if (d !== 32'h0 || r !== 2'b10) begin errors++; $display("FAIL oor_read: got %h/%b expected 0/10", d, r); end
    do_read(12'h000, d, r);
    checks++; if (d !== 32'h01020304) begin errors++; $display("FAIL oor_no_alias: got %h expected 01020304", d); end
    do_read(12'h3FC, d, r);
    checks++; if (d !== 32'hCAFEF00D || r !== 2'b00) begin errors++; $display("FAIL last_word_read: got %h/%b expected cafef00d/00", d, r); end
  endtask

  task automatic test_fetch_collision();
    logic [31:0] d; logic [1:0] r;
    checks++; if ({awready, wready, arready} !== 3'b111) begin errors++; $display("FAIL coll_idle: got %b expected 111", {awready, wready, arready}); end
    awvalid = 1'b1; awaddr = 12'h004; wvalid = 1'b1; wdata = 32'hBBBB0001; wstrb = 4'hF; bready = 1'b1;
    fetch_en = 1'b1; fetch_idx = 8'd0;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; fetch_idx = 8'd1;
    arvalid = 1'b1; araddr = 12'h004; rready = 1'b1;
    checks++; if (fetch_valid !== 1'b1 || fetch_data !== 32'h01020304) begin errors++; $display("FAIL coll_fetch0: got %b/%h expected 1/01020304", fetch_valid, fetch_data); end
    @(posedge clk); #1;
    arvalid = 1'b0; fetch_idx = 8'd2;
    checks++; if (fetch_data !== 32'hFF22FF44) begin errors++; $display("FAIL coll_fetch_old: got %h expected ff22ff44", fetch_data); end
    checks++; if (rvalid !== 1'b1 || rdata !== 32'hFF22FF44) begin errors++; $display("FAIL coll_axi_old: got %b/%h expected 1/ff22ff44", rvalid, rdata); end
    checks++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin errors++; $display("FAIL coll_bvalid: got %b/%b expected 1/00", bvalid, bresp); end
    @(posedge clk); #1;
    fetch_en = 1'b0;
    checks++; if (fetch_data !== 32'hDEADBEEF || bvalid !== 1'b0) begin errors++; $display("FAIL coll_fetch2: got %h/%b expected deadbeef/0", fetch_data, bvalid); end
    @(posedge clk); #1;
    checks++; if (fetch_valid !== 1'b0 || fetch_data !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_idle_hold: got %b/%h expected 0/deadbeef", fetch_valid, fetch_data); end
    fetch_en = 1'b1; fetch_idx = 8'd1;
    @(posedge clk); #1;
    fetch_en = 1'b0;
    checks++; if (fetch_valid !== 1'b1 || fetch_data !== 32'hBBBB0001) begin errors++; $display("FAIL coll_fetch_new: got %b/%h expected 1/bbbb0001", fetch_valid, fetch_data); end
    do_read(12'h004, d, r);
    checks++; if (d !== 32'hBBBB0001) begin errors++; $display("FAIL coll_axi_new: got %h expected bbbb0001", d); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  idx [5];
    logic [31:0] exp [5];
    idx = '{8'd3, 8'd2, 8'd255, 8'd1, 8'd0};
    exp = '{32'h0C0C0C0C, 32'hDEADBEEF, 32'hCAFEF00D, 32'hBBBB0001, 32'h01020304};
    for (int i = 0; i <= 5; i++) begin
      if (i < 5) begin fetch_en = 1'b1; fetch_idx = idx[i]; end
      else fetch_en = 1'b0;
      if (i > 0) begin
        checks++; if (fetch_valid !== 1'b1 || fetch_data !== exp[i-1]) begin errors++; $display("FAIL b2b_fetch%0d: got %b/%h expected 1/%h", i-1, fetch_valid, fetch_data, exp[i-1]); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wprotect();
    logic [1:0] r; int n; logic [31:0] d;
    cpu_run = 1'b0;
    do_write(12'h020, 32'h0F0F0F0F, 4'hF, 0, 0, r, n);
    cpu_run = 1'b1;
    do_write(12'h020, 32'h12345678, 4'hF, 0, 0, r, n);
    cpu_run = 1'b0;
    do_read(12'h020, d, r);
`ifdef INSTR_MEM_WPROTECT_EN
    checks++; if (d !== 32'h0F0F0F0F) begin errors++; $display("FAIL wprot_blocked: got %h expected 0f0f0f0f", d); end
`else
    checks++; if (d !== 32'h12345678) begin errors++; $display("FAIL wprot_ignored: got %h expected 12345678", d); end
`endif
    cpu_run = 1'b1;
    do_write(12'h024, 32'h12345678, 4'hF, 0, 0, r, n);
    cpu_run = 1'b0;
`ifdef INSTR_MEM_WPROTECT_EN
    checks++; if (r !== 2'b10 || n !== 1) begin errors++; $display("FAIL wprot_bresp: got %b/%0d expected 10/1", r, n); end
`else
    checks++; if (r !== 2'b00 || n !== 1) begin errors++; $display("FAIL wprot_bresp: got %b/%0d expected 00/1", r, n); end
`endif
    do_write(12'h020, 32'h12345678, 4'hF, 0, 0, r, n);
    checks++; if (r !== 2'b00) begin errors++; $display("FAIL wprot_run0_bresp: got %b expected 00", r); end
    do_read(12'h020, d, r);
    checks++; if (d !== 32'h12345678) begin errors++; $display("FAIL wprot_run0_read: got %h expected 12345678", d); end
  endtask

  task automatic test_reset_mid_write();
    logic [1:0] r; int n; logic [31:0] d;
    do_write(12'h010, 32'h10101010, 4'hF, 0, 0, r, n);
    awvalid = 1'b1; awaddr = 12'h010;
    @(posedge clk); #1;
    awvalid = 1'b0;
    checks++; if ({awready, wready} !== 2'b01) begin errors++; $display("FAIL aw_latched: got %b expected 01", {awready, wready}); end
    apply_reset();
    wvalid = 1'b1; wdata = 32'h55555555; wstrb = 4'hF;
    @(posedge clk); #1;
    wvalid = 1'b0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (bvalid) n++;
      @(posedge clk); #1;
    end
    checks++; if (n !== 0 || awready !== 1'b1) begin errors++; $display("FAIL aw_discarded: got bvalid_cycles=%0d awready=%b expected 0/1", n, awready); end
    do_write(12'h014, 32'h0, 4'h0, 0, 99, r, n);
    checks++; if (r !== 2'b00 || n !== 1) begin errors++; $display("FAIL aw_after_w: got %b/%0d expected 00/1", r, n); end
    do_read(12'h014, d, r);
    checks++; if (d !== 32'h55555555) begin errors++; $display("FAIL late_aw_data: got %h expected 55555555", d); end
    do_read(12'h010, d, r);
    checks++; if (d !== 32'h10101010) begin errors++; $display("FAIL reset_no_commit: got %h expected 10101010", d); end
  endtask

  task automatic test_rready_hold();
    rready = 1'b0; arvalid = 1'b1; araddr = 12'h008;
    @(posedge clk); #1;
    arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (rvalid !== 1'b1 || rdata !== 32'hDEADBEEF || arready !== 1'b0) begin errors++; $display("FAIL rhold_%0d: got %b/%h/%b expected 1/deadbeef/0", i, rvalid, rdata, arready); end
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checks++; if (rvalid !== 1'b0 || arready !== 1'b0 || rdata !== 32'h0) begin errors++; $display("FAIL rhold_reset: got %b/%b/%h expected 0/0/0", rvalid, arready, rdata); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rhold_no_resp%0d: got %b expected 0", i, rvalid); end
    end
    checks++; if (arready !== 1'b1) begin errors++; $display("FAIL rhold_arready: got %b expected 1", arready); end
    rready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic_write_read();
    test_strobe();
    test_out_of_range();
    test_fetch_collision();
    test_back_to_back();
    test_wprotect();
    test_reset_mid_write();
    test_rready_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
